// File: rtl/uart_hex_record_printer.sv
// rtl/uart_hex_record_printer.sv - captures one record of NUM_FIELDS words and prints it as ASCII hex over 8N1 UART
// Sequencer selects the current character; the transmitter serialises it and pulses tx_done per character.
module uart_hex_record_printer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W    = 32,
  parameter int PREFIX_EN  = 1,
  parameter int CRLF_EN    = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_FIELDS*FIELD_W-1:0] i_fields,
  input  logic                          i_we,
  input  logic                          i_drop_clr,
  output logic                          o_uart_tx,
  output logic                          o_ready,
  output logic [15:0]                   o_drop_cnt
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int NIBS  = FIELD_W / 4;
  localparam int TMR_W = $clog2(DIV);
  localparam int FLD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(DIV - 1);
  localparam logic [NIB_W-1:0] NIB_LAST   = NIB_W'(NIBS - 1);
  localparam logic [FLD_W-1:0] FLD_LAST   = FLD_W'(NUM_FIELDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PFX0, S_PFX1, S_HEX, S_SEP, S_EOL_CR, S_EOL_LF
  } seq_state_t;

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_state_t;

  localparam seq_state_t FIELD_ST = (PREFIX_EN != 0) ? S_PFX0 : S_HEX;
  localparam seq_state_t EOL_ST   = (CRLF_EN != 0) ? S_EOL_CR : S_EOL_LF;

  seq_state_t                      seq_q, seq_d;
  logic [FLD_W-1:0]                fld_q, fld_d;
  logic [NIB_W-1:0]                nib_q, nib_d;
  logic [NUM_FIELDS*FIELD_W-1:0]   cap_q, cap_d;
  logic                            arm_q, arm_d;
  tx_state_t                       tx_state_q, tx_state_d;
  logic [TMR_W-1:0]                tmr_q, tmr_d;
  logic [2:0]                      bit_q, bit_d;
  logic                            tx_q, tx_d;
  logic [15:0]                     drop_q, drop_d;

  logic                            tx_done;
  logic                            reject;
  logic [FIELD_W-1:0]              cur_field;
  logic [3:0]                      nib_val;
  logic [7:0]                      chr;

  assign o_ready    = (seq_q == S_IDLE);
  assign o_uart_tx  = tx_q;
  assign o_drop_cnt = drop_q;
  assign reject     = i_we && (seq_q != S_IDLE);

  always_comb begin
    cur_field = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (fld_q == FLD_W'(k)) cur_field = cap_q[k*FIELD_W +: FIELD_W];
    end
    nib_val = '0;
    for (int n = 0; n < NIBS; n++) begin
      if (nib_q == NIB_W'(n)) nib_val = cur_field[n*4 +: 4];
    end
  end

  always_comb begin
    chr = 8'h0A;
    case (seq_q)
      S_PFX0:   chr = 8'h30;
      S_PFX1:   chr = 8'h78;
      S_HEX:    chr = (nib_val < 4'd10) ? (8'h30 + {4'h0, nib_val}) : (8'h37 + {4'h0, nib_val});
      S_SEP:    chr = 8'h20;
      S_EOL_CR: chr = 8'h0D;
      default:  chr = 8'h0A;
    endcase
  end

  // The sequencer holds the character on the line until the transmitter finishes its stop bit.
  always_comb begin
    seq_d = seq_q;
    fld_d = fld_q;
    nib_d = nib_q;
    cap_d = cap_q;
    arm_d = (seq_q != S_IDLE);
    if (seq_q == S_IDLE) begin
      if (i_we) begin
        cap_d = i_fields;
        seq_d = FIELD_ST;
        fld_d = '0;
        nib_d = NIB_LAST;
      end
    end else if (tx_done) begin
      case (seq_q)
        S_PFX0: seq_d = S_PFX1;
        S_PFX1: seq_d = S_HEX;
        S_HEX: begin
          if (nib_q != '0)          nib_d = nib_q - 1'b1;
          else if (fld_q == FLD_LAST) seq_d = EOL_ST;
          else                      seq_d = S_SEP;
        end
        S_SEP: begin
          fld_d = fld_q + 1'b1;
          nib_d = NIB_LAST;
          seq_d = FIELD_ST;
        end
        S_EOL_CR: seq_d = S_EOL_LF;
        default:  seq_d = S_IDLE;
      endcase
    end
  end

  // arm_q delays the first start bit so it lands on the second edge after the accept.
  always_comb begin
    tx_state_d = tx_state_q;
    tmr_d      = tmr_q;
    bit_d      = bit_q;
    tx_done    = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if ((seq_q != S_IDLE) && arm_q) begin
          tx_state_d = T_START;
          tmr_d      = TMR_RELOAD;
        end
      end
      T_START: begin
        if (tmr_q == '0) begin
          tx_state_d = T_DATA;
          tmr_d      = TMR_RELOAD;
          bit_d      = 3'd0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      T_DATA: begin
        if (tmr_q == '0) begin
          tmr_d = TMR_RELOAD;
          if (bit_q == 3'd7) tx_state_d = T_STOP;
          else               bit_d = bit_q + 3'd1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: begin
        if (tmr_q == '0) begin
          tx_done = 1'b1;
          if (seq_q != S_EOL_LF) begin
            tx_state_d = T_START;
            tmr_d      = TMR_RELOAD;
          end else begin
            tx_state_d = T_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
    endcase
    case (tx_state_d)
      T_START: tx_d = 1'b0;
      T_DATA:  tx_d = chr[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (i_drop_clr)                     drop_d = reject ? 16'd1 : 16'd0;
    else if (reject && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seq_q      <= S_IDLE;
      fld_q      <= '0;
      nib_q      <= '0;
      cap_q      <= '0;
      arm_q      <= 1'b0;
      tx_state_q <= T_IDLE;
      tmr_q      <= '0;
      bit_q      <= 3'd0;
      tx_q       <= 1'b1;
      drop_q     <= 16'd0;
    end else begin
      seq_q      <= seq_d;
      fld_q      <= fld_d;
      nib_q      <= nib_d;
      cap_q      <= cap_d;
      arm_q      <= arm_d;
      tx_state_q <= tx_state_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      drop_q     <= drop_d;
    end
  end

endmodule
